multiplicador_seq: RTL
======================

// Module: multiplicador_seq
// PURPOSE
//  Parametrised sequential shift-add unsigned multiplier for the Multiplicador datapath.
//  - Accepts two WIDTH-bit operands on a start pulse and iterates one partial product per clock.
//  - Uses one 2*WIDTH-bit adder and returns a 2*WIDTH-bit product with a one-cycle done pulse.
//  - Sits between the ALU control path and the HI/LO result registers.
// PARAMETERS
//  WIDTH  8  operand width in bits; WIDTH >= 2. Product width = 2*WIDTH.
// PORTS
//  Clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous active-low reset
//  Inicio     in   1        start request; sampled only in IDLE
//  OperandoA  in   WIDTH    multiplicand, captured on accepted Inicio
//  OperandoB  in   WIDTH    multiplier, captured on accepted Inicio
//  Ocupado    out  1        high while state != IDLE
//  Pronto     out  1        one-cycle pulse: Produto is valid and final
//  Produto    out  2*WIDTH  result; holds its value until the next completion
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state=IDLE; Ocupado=0; Pronto=0; Produto=0.
//    Internal Acc, Mcand, Mplier and Cont all clear.
//    Reset mid-operation aborts the run. No Pronto is issued; Produto returns to 0.
//  - States:
//    IDLE -> CALC on Inicio=1.
//    CALC -> DONE after the last iteration.
//    DONE -> IDLE unconditionally.
//  - Accept (edge k, IDLE, Inicio=1): Acc<=0; Mcand<={WIDTH'b0,OperandoA}; Mplier<=OperandoB; Cont<=0.
//  - CALC iteration (one per edge):
//    - if Mplier[0], Acc <= Acc + Mcand (mod 2^(2*WIDTH); carry discarded, cannot overflow).
//    - then Mcand <<= 1; Mplier >>= 1; Cont <= Cont + 1.
//  - Last iteration is Cont == WIDTH-1. On that edge: state<=DONE; Produto<=final Acc; Pronto<=1.
//  - Latency: Pronto rises on the WIDTH-th edge after the accepting edge k.
//    Pronto lasts exactly one cycle (DONE). Ocupado falls on the next edge.
//  - Inicio in CALC or DONE is ignored; no queueing. Operands changing after acceptance have no effect.
//  - Inicio held high continuously: a new run is accepted on the first IDLE edge.
//    Back-to-back throughput is one product per WIDTH+2 cycles.
//  - Cont is $clog2(WIDTH) bits wide. It never wraps within a run.
// CONFIGURATION
//  MULT_EARLY_EXIT_EN
//  - Defined: an iteration is also the last when (Mplier>>1)==0, i.e. no set multiplier bits remain.
//    CALC lasts max(1, msb_index(OperandoB)+1) cycles. OperandoB=0 finishes after 1 CALC cycle.
//    Produto values are identical to the fixed-latency build.
//  - Undefined: fixed latency of WIDTH CALC cycles for all operands.
// STRUCTURE
//  - Package mult_pkg: state enum t_mult_estado {IDLE, CALC, DONE} and its 2-bit encoding.
//  - Sub-module adder_n:
//    - parameter N; inputs OperandoA, OperandoB [N-1:0]; output Soma [N:0].
//    - instanced once with N=2*WIDTH. Soma[N] is unused.
//  - One sequential always block holds state and the datapath registers. Next-state logic is combinational.
// TESTING
//  1. WIDTH=4, A=15, B=15, Inicio pulse:
//     Produto=225; Pronto high exactly on the 4th edge after accept, one cycle; Ocupado high for 5 cycles.
//  2. WIDTH=4, exhaustive A,B in 0..15: every Produto == A*B; exactly one Pronto per start.
//  3. WIDTH=8, A=200, B=3, then Inicio re-pulsed mid-CALC with A=1, B=1:
//     second request ignored; Produto=600; single Pronto.
//  4. WIDTH=8, Reset_n low 3 cycles into CALC:
//     Ocupado=0, Pronto=0 and Produto=0 immediately; no Pronto after release; a new run then gives correct results.
//  5. MULT_EARLY_EXIT_EN, WIDTH=8:
//     A=7, B=1 -> Pronto on 1st edge, Produto=7.
//     A=9, B=0 -> 1st edge, 0.
//     A=255, B=255 -> 8th edge, 65025.
//  6. Inicio held high for 30 cycles, WIDTH=4, A=2, B=3:
//     Produto=6 and a Pronto every 6 cycles; Produto stable between pulses.

Source files
------------

// File: rtl/mult_pkg.sv
// Purpose : shared state encoding for the sequential shift-add multiplier.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   t_mult_estado  2-bit controller state {IDLE, CALC, DONE}
//   cont_width()   width of the iteration counter for a given operand width
package mult_pkg;

  // Explicit 2-bit encoding so the state register width is fixed regardless
  // of how the enum is later extended or inspected in a waveform.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } t_mult_estado;

  // Iteration counter width: enough to hold 0..w-1. The multiplier requires
  // w >= 2, so $clog2 never returns 0 here; the guard keeps the function
  // safe if it is reused elsewhere.
  function automatic int cont_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Purpose : N-bit unsigned adder with carry out, the single adder of the multiplier datapath.
// Latency : combinational, zero cycles.
// Backpressure: none; purely combinational.
//
// Ports:
//   OperandoA  in  [N-1:0]  first addend
//   OperandoB  in  [N-1:0]  second addend
//   Soma       out [N:0]    sum, Soma[N] is the carry out
module adder_n #(
  parameter int N = 16
) (
  input  logic [N-1:0] OperandoA,
  input  logic [N-1:0] OperandoB,
  output logic [N:0]   Soma
);

  // Zero-extend both addends so the carry lands in Soma[N].
  assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

// File: rtl/multiplicador_seq.sv
// Purpose : sequential shift-add unsigned multiplier, one partial product per clock.
// Latency : Pronto rises WIDTH edges after the accepting edge (fewer with MULT_EARLY_EXIT_EN).
// Backpressure: none; Inicio is only sampled in IDLE, requests while busy are dropped.
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   defined   -> the run also ends once no set multiplier bits remain
//   undefined -> fixed WIDTH iterations for every operand pair
//
// Ports:
//   Clk        in   1          rising-edge clock
//   Reset_n    in   1          asynchronous active-low reset
//   Inicio     in   1          start request, sampled only in IDLE
//   OperandoA  in   WIDTH      multiplicand, captured on an accepted Inicio
//   OperandoB  in   WIDTH      multiplier, captured on an accepted Inicio
//   Ocupado    out  1          high while the controller is not IDLE
//   Pronto     out  1          one-cycle pulse, Produto is valid and final
//   Produto    out  2*WIDTH    result, held until the next completion
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Inicio,
  input  logic [WIDTH-1:0]   OperandoA,
  input  logic [WIDTH-1:0]   OperandoB,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [2*WIDTH-1:0] Produto
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cont_width(WIDTH);
  localparam logic [CW-1:0] CONT_LAST = CW'(WIDTH - 1);

  t_mult_estado   estado;
  t_mult_estado   estado_next;

  // Datapath registers. The multiplicand lives in a double-width register so
  // that shifting it left each iteration lines it up with the next partial
  // product without a separate barrel shifter.
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cont;

  logic [PW-1:0]    parcela;
  logic [PW:0]      soma;
  logic [PW-1:0]    acc_next;
  logic             carry_unused;
  logic             ultima;

  // Partial product for this iteration: the shifted multiplicand when the
  // current multiplier LSB is set, otherwise nothing.
  assign parcela = mplier[0] ? mcand : '0;

  adder_n #(
    .N(PW)
  ) u_adder (
    .OperandoA (acc),
    .OperandoB (parcela),
    .Soma      (soma)
  );

  // The product of two WIDTH-bit values always fits in 2*WIDTH bits, so the
  // carry out of the accumulator adder can never be set.
  assign acc_next     = soma[PW-1:0];
  assign carry_unused = soma[PW];

  // Last-iteration detect. In the early-exit build the run also stops when
  // the bits still to be consumed (everything above the current LSB) are
  // all zero: no further partial product can change the accumulator.
  always_comb begin
    ultima = 1'b0;
`ifdef MULT_EARLY_EXIT_EN
    ultima = (cont == CONT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
    ultima = (cont == CONT_LAST);
`endif
  end

  // Controller next state.
  always_comb begin
    estado_next = estado;
    case (estado)
      IDLE:    if (Inicio) estado_next = CALC;
      CALC:    if (ultima) estado_next = DONE;
      DONE:    estado_next = IDLE;
      default: estado_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs in one block so that Ocupado,
  // Pronto and Produto all change on the same edge as the state they
  // describe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      estado  <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cont    <= '0;
      Ocupado <= 1'b0;
      Pronto  <= 1'b0;
      Produto <= '0;
    end else begin
      estado  <= estado_next;
      // Ocupado mirrors the state being entered, so it is high exactly while
      // the registered state is CALC or DONE.
      Ocupado <= (estado_next != IDLE);
      Pronto  <= 1'b0;

      case (estado)
        IDLE: begin
          if (Inicio) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, OperandoA};
            mplier <= OperandoB;
            cont   <= '0;
          end
        end

        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Hold the counter on the final iteration so it never wraps, even
          // when WIDTH is a power of two and CONT_LAST is all ones.
          if (!ultima) begin
            cont <= cont + CW'(1);
          end
          if (ultima) begin
            // Publish the accumulator including this iteration's partial
            // product, not the stale registered value.
            Produto <= acc_next;
            Pronto  <= 1'b1;
          end
        end

        default: begin
          // DONE: outputs already published, nothing to update.
        end
      endcase
    end
  end

endmodule
